sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO for buffering byte or word streams inside one clock domain.
Generalises the 16x8 dual-clock FIFO to configurable width and depth.
Adds an occupancy count, programmable almost-full/almost-empty thresholds, a registered read-valid strobe, and sticky overflow/underflow error flags.
Pointer synchronisers are dropped; both pointers live in one domain.

---
 rtl/sync_fifo_param.sv | 108 ++++++++++
 tb/tb_sync_fifo_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// a registered read-valid strobe and sticky overflow/underflow flags.
module sync_fifo_param #(
   parameter int unsigned DATA_WIDTH          = 8,
   parameter int unsigned ADDR_WIDTH          = 4,
   parameter int unsigned ALMOST_FULL_THRESH  = 14,
   parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic                  clear_errors,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fill_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] wptr_nxt;
   logic [PTR_W-1:0] rptr_nxt;
   logic [PTR_W-1:0] count_nxt;
   logic             wr_accept;
   logic             rd_accept;

   // Accept decisions use only registered flags, never the raw requests' effects.
   always_comb begin
      wr_accept = write_enable && !fifo_full;
      rd_accept = read_enable && !fifo_empty;
      wptr_nxt  = wptr + PTR_W'(wr_accept);
      rptr_nxt  = rptr + PTR_W'(rd_accept);
      count_nxt = wptr_nxt - rptr_nxt;
   end

   // Pointers, occupancy and status flags, all registered from next-state values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr         <= '0;
         rptr         <= '0;
         fill_count   <= '0;
         fifo_full    <= 1'b0;
         fifo_empty   <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wptr         <= wptr_nxt;
         rptr         <= rptr_nxt;
         fill_count   <= count_nxt;
         fifo_full    <= (count_nxt == PTR_W'(DEPTH));
         fifo_empty   <= (count_nxt == '0);
         almost_full  <= (count_nxt >= PTR_W'(ALMOST_FULL_THRESH));
         almost_empty <= (count_nxt <= PTR_W'(ALMOST_EMPTY_THRESH));
      end
   end

   // Storage array is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_accept) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= write_data;
      end
   end

   // Read port: data holds its last value when no read is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= rd_accept;
         if (rd_accept) begin
            read_data <= mem[rptr[ADDR_WIDTH-1:0]];
         end
      end
   end

   // Sticky error flags; a new error event wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (write_enable && fifo_full) begin
            overflow <= 1'b1;
         end else if (clear_errors) begin
            overflow <= 1'b0;
         end
         if (read_enable && fifo_empty) begin
            underflow <= 1'b1;
         end else if (clear_errors) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: default 16x8 instance and a 4x32 instance.
module tb_sync_fifo_param;

   logic       clk;
   logic       rst_n;
   logic [7:0] wd;
   logic       we;
   logic       re;
   logic       clr;
   logic [7:0] rd;
   logic       rv;
   logic       full;
   logic       empty;
   logic       afull;
   logic       aempty;
   logic [4:0] cnt;
   logic       ovf;
   logic       udf;

   logic [31:0] p_wd;
   logic        p_we;
   logic        p_re;
   logic [31:0] p_rd;
   logic        p_rv;
   logic        p_full;
   logic        p_empty;
   logic        p_afull;
   logic        p_aempty;
   logic [2:0]  p_cnt;
   logic        p_ovf;
   logic        p_udf;

   int checks;
   int failures;

   sync_fifo_param u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_data   (wd),
      .write_enable (we),
      .read_enable  (re),
      .clear_errors (clr),
      .read_data    (rd),
      .read_valid   (rv),
      .fifo_full    (full),
      .fifo_empty   (empty),
      .almost_full  (afull),
      .almost_empty (aempty),
      .fill_count   (cnt),
      .overflow     (ovf),
      .underflow    (udf)
   );

   sync_fifo_param #(
      .DATA_WIDTH          (32),
      .ADDR_WIDTH          (2),
      .ALMOST_FULL_THRESH  (3),
      .ALMOST_EMPTY_THRESH (1)
   ) u_dut_w32 (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_data   (p_wd),
      .write_enable (p_we),
      .read_enable  (p_re),
      .clear_errors (clr),
      .read_data    (p_rd),
      .read_valid   (p_rv),
      .fifo_full    (p_full),
      .fifo_empty   (p_empty),
      .almost_full  (p_afull),
      .almost_empty (p_aempty),
      .fill_count   (p_cnt),
      .overflow     (p_ovf),
      .underflow    (p_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; wd = '0;
      p_we = 1'b0; p_re = 1'b0; p_wd = '0;

      // Reset and defaults
      step(); step();
      rst_n = 1'b1;
      step();
      check("rst_cnt", 32'(cnt), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_aempty", 32'(aempty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_afull", 32'(afull), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_udf", 32'(udf), 0);
      check("rst_rv", 32'(rv), 0);
      check("rst_rd", 32'(rd), 0);

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; wd = 8'(i);
         step();
         if (i == 1)  check("fill_aempty_c2", 32'(aempty), 1);
         if (i == 2)  check("fill_aempty_c3", 32'(aempty), 0);
         if (i == 12) check("fill_afull_c13", 32'(afull), 0);
         if (i == 13) check("fill_afull_c14", 32'(afull), 1);
         if (i == 14) check("fill_full_c15", 32'(full), 0);
      end
      we = 1'b0;
      check("fill_full", 32'(full), 1);
      check("fill_cnt", 32'(cnt), 16);

      // Overflowing write
      we = 1'b1; wd = 8'hAA;
      step();
      we = 1'b0;
      check("ovf_set", 32'(ovf), 1);
      check("ovf_cnt", 32'(cnt), 16);

      // Drain in order
      re = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         check("drain_rv", 32'(rv), 1);
         check("drain_rd", 32'(rd), 32'(i));
         check("drain_cnt", 32'(cnt), 32'(15 - i));
         check("drain_aempty", 32'(aempty), (15 - i) <= 2 ? 1 : 0);
      end
      re = 1'b0;
      check("drain_empty", 32'(empty), 1);
      step();
      check("idle_rv", 32'(rv), 0);

      // Underflow
      re = 1'b1;
      step();
      re = 1'b0;
      check("udf_set", 32'(udf), 1);
      check("udf_rv", 32'(rv), 0);
      check("udf_rd_hold", 32'(rd), 32'h0F);

      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_ovf", 32'(ovf), 0);
      check("clr_udf", 32'(udf), 0);

      // Refill with 0x20..0x2F, then clear racing a new overflow
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; wd = 8'(32'h20 + i);
         step();
      end
      clr = 1'b1;
      step();
      we = 1'b0; clr = 1'b0;
      check("clr_vs_set_ovf", 32'(ovf), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_ovf2", 32'(ovf), 0);

      // Write+read at full
      we = 1'b1; re = 1'b1; wd = 8'hBB;
      step();
      we = 1'b0; re = 1'b0;
      check("full_wr_cnt", 32'(cnt), 15);
      check("full_wr_ovf", 32'(ovf), 1);
      check("full_wr_rv", 32'(rv), 1);
      check("full_wr_rd", 32'(rd), 32'h20);
      re = 1'b1;
      for (int i = 1; i < 16; i++) begin
         step();
         check("refill_rd", 32'(rd), 32'(32'h20 + i));
      end
      re = 1'b0;
      check("refill_empty", 32'(empty), 1);

      // Write+read at empty
      we = 1'b1; re = 1'b1; wd = 8'hCC;
      step();
      we = 1'b0; re = 1'b0;
      check("empty_wr_cnt", 32'(cnt), 1);
      check("empty_wr_udf", 32'(udf), 1);
      check("empty_wr_rv", 32'(rv), 0);
      re = 1'b1;
      step();
      re = 1'b0;
      check("empty_wr_rd", 32'(rd), 32'hCC);
      check("empty_wr_rv2", 32'(rv), 1);

      // Steady state at fill_count 5 across a pointer wrap
      for (int k = 0; k < 5; k++) begin
         we = 1'b1; wd = 8'(32'h40 + k);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         we = 1'b1; re = 1'b1; wd = 8'(32'h45 + i);
         step();
         check("stream_rd", 32'(rd), 32'(32'h40 + i));
         check("stream_cnt", 32'(cnt), 5);
      end
      we = 1'b0; re = 1'b0;

      // Reset mid-operation with 7 queued
      for (int k = 0; k < 2; k++) begin
         we = 1'b1; wd = 8'(32'h60 + k);
         step();
      end
      we = 1'b0;
      check("pre_rst_cnt", 32'(cnt), 7);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_cnt", 32'(cnt), 0);
      check("mid_rst_empty", 32'(empty), 1);
      check("mid_rst_rv", 32'(rv), 0);
      check("mid_rst_udf", 32'(udf), 0);
      we = 1'b1; wd = 8'h5C;
      step();
      we = 1'b0; re = 1'b1;
      step();
      re = 1'b0;
      check("post_rst_rv", 32'(rv), 1);
      check("post_rst_rd", 32'(rd), 32'h5C);

      // 4-deep 32-bit instance
      for (int i = 0; i < 4; i++) begin
         p_we = 1'b1; p_wd = 32'hDEAD_BEE0 + 32'(i);
         step();
         if (i == 0) check("w32_aempty_c1", 32'(p_aempty), 1);
         if (i == 1) check("w32_aempty_c2", 32'(p_aempty), 0);
         if (i == 1) check("w32_afull_c2", 32'(p_afull), 0);
         if (i == 2) check("w32_afull_c3", 32'(p_afull), 1);
         if (i == 2) check("w32_full_c3", 32'(p_full), 0);
      end
      p_we = 1'b0;
      check("w32_full", 32'(p_full), 1);
      check("w32_cnt", 32'(p_cnt), 4);
      p_re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("w32_rv", 32'(p_rv), 1);
         check("w32_rd", p_rd, 32'hDEAD_BEE0 + 32'(i));
      end
      p_re = 1'b0;
      check("w32_empty", 32'(p_empty), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
